// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared types, digit moduli and terminal-word helper for the
//               MM:SS timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int c_mod_ten = 10;
  localparam int c_mod_six = 6;

  // Counting up stops at the top of the range, counting down stops at 00:00.
  function automatic logic [15:0] terminal_word(input logic up, input int tens_mod);
    logic [3:0] tens_max;
    tens_max = 4'(tens_mod - 1);
    return up ? {tens_max, 4'd9, 4'd5, 4'd9} : 16'h0000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_cell.sv
// ============================================================================
// Module      : bcd_digit_cell
// Description : One BCD digit of modulus MOD; combinational up/down step with
//               carry/borrow out for chaining.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_cell #(
  parameter int MOD = 10
) (
  input  logic [3:0] digit,
  input  logic       step,
  input  logic       up,
  output logic [3:0] next,
  output logic       carry
);

  localparam logic [3:0] c_max = 4'(MOD - 1);

  always_comb begin
    next  = digit;
    carry = 1'b0;
    if (step) begin
      if (up) begin
        if (digit == c_max) begin
          next  = 4'd0;
          carry = 1'b1;
        end else begin
          next = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          next  = c_max;
          carry = 1'b1;
        end else begin
          next = digit - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmss_timer.sv
// ============================================================================
// Module      : mmss_timer
// Description : MM:SS countdown/stopwatch with run-control FSM, tick divider,
//               edit path and terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmss_timer
  import timer_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int TICK_HZ      = 1,
  parameter int MIN_TENS_MOD = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  input  logic        stop,
  input  logic        mode_up,
  input  logic        inc,
  input  logic        dec,
  input  logic        min,
  output logic [15:0] time_reading,
  output logic        complete,
  output logic        running,
  output logic [1:0]  state
);

  localparam int c_div   = CLK_FREQ / TICK_HZ;
  localparam int c_cnt_w = $clog2(c_div);
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(c_div - 1);

  state_t             r_state, w_state_next;
  logic [15:0]        r_time, w_time_next;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
  logic               r_mode_up, w_mode_next;
  logic               r_complete, w_complete_next;
  logic               r_running;

  logic        w_tick;
  logic        w_up;
  logic        w_edit_min;
  logic [15:0] w_stepped;
  logic        w_c0, w_c1, w_c2, w_c3;

  assign w_tick     = (r_cnt == '0);
  assign w_up       = (r_state == ST_RUN) ? r_mode_up : inc;
  assign w_edit_min = (r_state != ST_RUN) && min;

  // The chain always produces the one-step neighbour; the FSM decides whether to take it.
  bcd_digit_cell #(.MOD(c_mod_ten)) u_ones_sec (
    .digit (r_time[3:0]),   .step (~w_edit_min),       .up (w_up),
    .next  (w_stepped[3:0]), .carry (w_c0)
  );
  bcd_digit_cell #(.MOD(c_mod_six)) u_tens_sec (
    .digit (r_time[7:4]),   .step (w_c0),              .up (w_up),
    .next  (w_stepped[7:4]), .carry (w_c1)
  );
  bcd_digit_cell #(.MOD(c_mod_ten)) u_ones_min (
    .digit (r_time[11:8]),  .step (w_c1 | w_edit_min), .up (w_up),
    .next  (w_stepped[11:8]), .carry (w_c2)
  );
  bcd_digit_cell #(.MOD(MIN_TENS_MOD)) u_tens_min (
    .digit (r_time[15:12]), .step (w_c2),              .up (w_up),
    .next  (w_stepped[15:12]), .carry (w_c3)
  );

  always_comb begin
    w_state_next    = r_state;
    w_time_next     = r_time;
    w_cnt_next      = r_cnt;
    w_mode_next     = r_mode_up;
    w_complete_next = 1'b0;
    if (clear) begin
      w_state_next = ST_IDLE;
      w_time_next  = 16'h0000;
      w_cnt_next   = c_reload;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          if (stop) begin
            w_state_next = r_state;
          end else if (start) begin
            w_mode_next = mode_up;
            w_cnt_next  = c_reload;
            if (r_time == terminal_word(mode_up, MIN_TENS_MOD)) begin
              w_state_next    = ST_DONE;
              w_complete_next = 1'b1;
            end else begin
              w_state_next = ST_RUN;
            end
          end else if (inc ^ dec) begin
            w_time_next = w_stepped;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            w_cnt_next = c_reload;
            if (stop) begin
              w_state_next = ST_PAUSE;
            end else begin
              w_time_next = w_stepped;
              if (w_stepped == terminal_word(r_mode_up, MIN_TENS_MOD)) begin
                w_state_next    = ST_DONE;
                w_complete_next = 1'b1;
              end
            end
          end else if (stop) begin
            w_state_next = ST_PAUSE;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_time     <= 16'h0000;
      r_cnt      <= c_reload;
      r_mode_up  <= 1'b0;
      r_complete <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_time     <= w_time_next;
      r_cnt      <= w_cnt_next;
      r_mode_up  <= w_mode_next;
      r_complete <= w_complete_next;
      r_running  <= (w_state_next == ST_RUN);
    end
  end

  assign time_reading = r_time;
  assign complete     = r_complete;
  assign running      = r_running;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mmss_timer.sv
// ============================================================================
// Module      : tb_mmss_timer
// Description : Self-checking bench for mmss_timer against a seconds-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmss_timer;

  localparam int c_div   = 20;
  localparam int c_tmod  = 2;
  localparam int c_total = c_tmod * 600;

  logic        clk, rst_n;
  logic        clear, start, stop, mode_up, inc, dec, min;
  logic [15:0] time_reading;
  logic        complete, running;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time as total seconds, run phase as elapsed cycles.
  int m_state = 0;
  int m_secs  = 0;
  int m_up    = 0;
  int m_el    = 0;
  int m_comp  = 0;

  mmss_timer #(.CLK_FREQ(c_div), .TICK_HZ(1), .MIN_TENS_MOD(c_tmod)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .stop(stop),
    .mode_up(mode_up), .inc(inc), .dec(dec), .min(min),
    .time_reading(time_reading), .complete(complete), .running(running),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int term(input int up);
    return up ? c_total - 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_up = 0; m_el = 0; m_comp = 0;
  endtask

  task automatic model_edge();
    int delta;
    m_comp = 0;
    if (!rst_n) begin
      model_reset();
    end else if (clear) begin
      m_state = 0; m_secs = 0; m_el = 0;
    end else if (m_state == 0 || m_state == 2) begin
      if (stop) begin
      end else if (start) begin
        m_up = int'(mode_up);
        m_el = 0;
        if (m_secs == term(m_up)) begin
          m_state = 3; m_comp = 1;
        end else begin
          m_state = 1;
        end
      end else if (inc != dec) begin
        delta  = min ? 60 : 1;
        m_secs = inc ? (m_secs + delta) % c_total : (m_secs + c_total - delta) % c_total;
      end
    end else if (m_state == 1) begin
      if (stop) begin
        m_state = 2;
      end else begin
        m_el++;
        if (m_el == c_div) begin
          m_el   = 0;
          m_secs = m_up ? m_secs + 1 : m_secs - 1;
          if (m_secs == term(m_up)) begin
            m_state = 3; m_comp = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("time", 32'(time_reading), 32'(to_bcd(m_secs)));
    check("state", 32'(state), 32'(m_state));
    check("complete", 32'(complete), 32'(m_comp));
    check("running", 32'(running), 32'(m_state == 1));
  endtask

  task automatic cyc(input bit cl, input bit st, input bit sp, input bit mu,
                     input bit ic, input bit dc, input bit mn);
    clear = cl; start = st; stop = sp; mode_up = mu; inc = ic; dec = dc; min = mn;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, mode_up, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 0; start = 0; stop = 0; mode_up = 0; inc = 0; dec = 0; min = 0;
    idle(3);
    rst_n = 1'b1;

    // reset then clear, idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(30);
    check("idle_time", 32'(time_reading), 32'h0000);
    check("idle_state", 32'(state), 32'd0);

    // countdown from 00:03
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    check("preset_0003", 32'(time_reading), 32'h0003);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (i == 20) check("cd_0002", 32'(time_reading), 32'h0002);
      if (i == 40) check("cd_0001", 32'(time_reading), 32'h0001);
      if (i == 59) check("cd_nocomp", 32'(complete), 32'd0);
    end
    check("cd_0000", 32'(time_reading), 32'h0000);
    check("cd_complete", 32'(complete), 32'd1);
    check("cd_done", 32'(state), 32'd3);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("done_start_ign", 32'(state), 32'd3);
    check("done_comp_once", 32'(complete), 32'd0);

    // stopwatch to terminal 19:59
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("edit_1958", 32'(time_reading), 32'h1958);
    cyc(0, 1, 0, 1, 0, 0, 0);
    idle(20);
    check("up_1959", 32'(time_reading), 32'h1959);
    check("up_done", 32'(state), 32'd3);
    check("up_complete", 32'(complete), 32'd1);

    // range wrap on edits
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("wrap_dec", 32'(time_reading), 32'h1959);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("wrap_inc", 32'(time_reading), 32'h0000);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("min_inc", 32'(time_reading), 32'h0100);
    cyc(0, 0, 0, 0, 0, 1, 1);

    // pause and resume
    cyc(0, 1, 0, 1, 0, 0, 0);
    idle(24);
    cyc(0, 0, 1, 1, 0, 0, 0);
    check("pause_0001", 32'(time_reading), 32'h0001);
    check("pause_state", 32'(state), 32'd2);
    idle(5);
    cyc(0, 0, 0, 1, 1, 0, 1);
    check("pause_min", 32'(time_reading), 32'h0101);
    cyc(0, 1, 0, 1, 0, 0, 0);
    idle(19);
    check("resume_hold", 32'(time_reading), 32'h0101);
    idle(1);
    check("resume_step", 32'(time_reading), 32'h0102);

    // simultaneous controls
    idle(7);
    cyc(1, 1, 1, 1, 0, 0, 0);
    check("sim_idle", 32'(state), 32'd0);
    check("sim_zero", 32'(time_reading), 32'h0000);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("incdec", 32'(time_reading), 32'h0001);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("start_term_done", 32'(state), 32'd3);
    check("start_term_comp", 32'(complete), 32'd1);

    // async reset mid-run
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    idle(30);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_time", 32'(time_reading), 32'h0000);
    check("arst_state", 32'(state), 32'd0);
    check("arst_run", 32'(running), 32'd0);
    check("arst_comp", 32'(complete), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(25);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 39) == 0, 1'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmss_timer.md
# mmss_timer

Parametrised MM:SS countdown/stopwatch core for the board's timer display path. It generalises the single-mode seconds counter with:
- selectable tick rate and upper tens-of-minutes range;
- run-time up/down mode and pause/resume;
- an explicit run-control state machine;
- a terminal-count pulse.

The BCD time word drives the seven-segment multiplexer; control inputs arrive pre-debounced, single-cycle pulses from the button front end.

## Interface
- CLK_FREQ, 100000000, clock frequency in Hz
- TICK_HZ, 1, count ticks per second; DIV = CLK_FREQ/TICK_HZ, integer, ≥2
- MIN_TENS_MOD, 6, modulus of tens-of-minutes digit, 2..10; max reading = (MIN_TENS_MOD-1)9:59

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous pulse: zero time, go IDLE
- start  in  1  pulse: begin/resume counting
- stop  in  1  pulse: pause counting
- mode_up  in  1  level, 1 = count up, 0 = count down; latched on start
- inc, dec  in  1  edit pulses
- min  in  1  level, edit target: 1 = minutes, 0 = seconds
- time_reading  out  16  BCD {tens_min, ones_min, tens_sec, ones_sec}, unused upper bits 0
- complete  out  1  one-cycle pulse on reaching terminal value
- running  out  1  high in RUN
- state  out  2  current FSM state

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Transitions:
  - IDLE/PAUSE + start → RUN, latching mode_up.
  - RUN + stop → PAUSE.
  - RUN + terminal reached on tick → DONE.
  - DONE + start → ignored.
  - Any state + clear → IDLE, time 00:00.
- Priority when simultaneous: clear > stop > start; edits are ignored in the same cycle as any of these.
- Edits: inc/dec are accepted only in IDLE and PAUSE.
  - min=0 steps ones_sec with cascade into tens_sec, ones_min, tens_min.
  - min=1 steps ones_min with cascade into tens_min.
  - Whole range wraps: max+1 → 00:00; 00:00-1 → max.
  - inc&dec together → no change.
- Counting: in RUN, each tick steps the time by one second in the latched direction, with per-digit moduli 10/6/10/MIN_TENS_MOD.
- Terminal value: 00:00 when counting down; max when counting up. On the tick producing it, time holds there, state → DONE, and complete pulses.
- Start at terminal: start in IDLE/PAUSE with time already at the terminal value for the latched mode → DONE on the next edge plus a complete pulse, with no tick wait.
- DONE: time frozen, edits ignored; only clear (or reset) leaves it.

## Timing
- Reset (rst_n low, asynchronous): time 00:00, state IDLE, complete 0, running 0, tick counter DIV-1.
- The tick counter reloads to DIV-1 on the start edge and on each tick; it holds in PAUSE and resets on clear.
- First step lands DIV cycles after the start edge; subsequent steps every DIV cycles.
- Edit latency: time_reading updates on the clock edge sampling inc/dec.
- State transitions take effect on the sampling edge.
- complete and running are registered. complete is high for exactly one cycle, coincident with state reading DONE for the first cycle.
- Reset mid-RUN aborts immediately, with no complete pulse.
- Stop on the same cycle as a tick: stop wins and the tick step is discarded. The counter holds its reload, so resume gives a full DIV period.

## Structure
- Package timer_pkg:
  - state encoding;
  - digit modulus constants (10, 6);
  - function computing the terminal word from direction and MIN_TENS_MOD.
- Sub-module bcd_digit_cell #(MOD): combinational next-value with up/down request in, carry/borrow out.
  - Four instances are chained by carry/borrow.
  - The top-level FSM, tick divider and edit/count muxing sit in mmss_timer.

## Test plan
- Reset then clear; idle 30 cycles → time_reading 16'h0000, state 0, complete never high.
- Use CLK_FREQ=20, TICK_HZ=1 (DIV=20) for the run tests below.
- Countdown: preset 00:03 via three inc (min=0), start with mode_up=0 → readings 0002/0001/0000 at 20/40/60 cycles after start; complete high exactly cycle 60 only; state DONE.
- Stopwatch wrap/terminal: MIN_TENS_MOD=2, edit to 19:58, start with mode_up=1 → 1959 then DONE at 19:59 with complete pulse.
  - Separately, inc at 19:59 in IDLE → 0000.
  - dec at 0000 → 1959.
- Pause: start, stop after 25 cycles → reading frozen at one step.
  - inc with min=1 adds 1 minute.
  - start → next step exactly 20 cycles later.
- Simultaneous: start+stop+clear same cycle in RUN → IDLE, 0000.
  - inc+dec together in IDLE → unchanged.
  - start at 00:00 mode down → DONE plus complete next edge.
- Async reset asserted mid-RUN between clock edges → outputs zero immediately, no complete pulse.
